// File: rtl/branch_predict_unit_if.sv
// Bundle of fetch-prediction and branch-resolve signals for branch_predict_unit.
// The master side (pipeline) drives PCs and operands; the slave side (the unit)
// returns the prediction and the registered resolve results.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    // Fetch-side lookup
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_pred_taken;

    // Resolve request
    logic            res_valid;
    logic [XLEN-1:0] res_pc;
    logic [2:0]      res_func3;
    logic [XLEN-1:0] res_rs1;
    logic [XLEN-1:0] res_rs2;
    logic            res_pred_taken;

    // Registered resolve results
    logic            out_valid;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
    logic [31:0]     mispredict_count;

    modport master (
        output fetch_pc,
        output res_valid,
        output res_pc,
        output res_func3,
        output res_rs1,
        output res_rs2,
        output res_pred_taken,
        input  fetch_pred_taken,
        input  out_valid,
        input  out_taken,
        input  out_mispredict,
        input  out_illegal,
        input  mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  res_valid,
        input  res_pc,
        input  res_func3,
        input  res_rs1,
        input  res_rs2,
        input  res_pred_taken,
        output fetch_pred_taken,
        output out_valid,
        output out_taken,
        output out_mispredict,
        output out_illegal,
        output mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit.
// Resolves the six RISC-V conditional branches straight from the register
// operands, registers the outcome one cycle later, flags mispredictions against
// the prediction carried down the pipe and trains a table of 2-bit saturating
// counters that the fetch stage reads combinationally.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predict_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Counter encodings: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    // Table index: word-aligned PC bits just above the byte offset.
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;

    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign res_idx   = bus.res_pc[IDX_W+1:2];

    // PC bits outside the index field play no part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                              bus.res_pc[XLEN-1:IDX_W+2],   bus.res_pc[1:0]};

    // ------------------------------------------------------------------
    // Branch condition evaluation
    // ------------------------------------------------------------------
    logic ops_eq;
    logic ops_lt_s;
    logic ops_lt_u;

    assign ops_eq   = (bus.res_rs1 == bus.res_rs2);
    assign ops_lt_s = ($signed(bus.res_rs1) < $signed(bus.res_rs2));
    assign ops_lt_u = (bus.res_rs1 < bus.res_rs2);

    logic taken_raw;
    logic illegal_raw;

    // Decode funct3 into an outcome; the two reserved encodings are illegal and never taken.
    always_comb begin
        taken_raw   = 1'b0;
        illegal_raw = 1'b0;
        unique case (bus.res_func3)
            3'b000:  taken_raw = ops_eq;
            3'b001:  taken_raw = ~ops_eq;
            3'b100:  taken_raw = ops_lt_s;
            3'b101:  taken_raw = ~ops_lt_s;
            3'b110:  taken_raw = ops_lt_u;
            3'b111:  taken_raw = ~ops_lt_u;
            default: illegal_raw = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------
    logic [1:0] bht_rd [BHT_DEPTH];
    logic       train_en;
    logic [1:0] train_cur;
    logic [1:0] train_ctr_d;

    assign train_en  = bus.res_valid & ~illegal_raw;
    assign train_cur = bht_rd[res_idx];

    // Saturating step of the counter addressed by the resolving branch.
    always_comb begin
        train_ctr_d = train_cur;
        if (taken_raw) begin
            if (train_cur != CTR_MAX) begin
                train_ctr_d = train_cur + 2'd1;
            end
        end else begin
            if (train_cur != CTR_MIN) begin
                train_ctr_d = train_cur - 2'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic [1:0] ctr_q;
            logic       hit;

            assign hit       = train_en && (res_idx == IDX_W'(gi));
            assign bht_rd[gi] = ctr_q;

            // One counter per entry; only the addressed entry moves on a legal resolve.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_q <= CTR_RESET;
                end else if (hit) begin
                    ctr_q <= train_ctr_d;
                end
            end
        end
    endgenerate

    // Fetch reads the stored value directly, so a same-cycle update is not forwarded.
    assign bus.fetch_pred_taken = bht_rd[fetch_idx][1];

    // ------------------------------------------------------------------
    // Registered resolve results
    // ------------------------------------------------------------------
    logic        out_valid_q,      out_valid_d;
    logic        out_taken_q,      out_taken_d;
    logic        out_mispredict_q, out_mispredict_d;
    logic        out_illegal_q,    out_illegal_d;
    logic [31:0] mp_count_q,       mp_count_d;

    // Next-state of the result fields; idle cycles clear every flag.
    always_comb begin
        out_valid_d      = bus.res_valid;
        out_taken_d      = bus.res_valid & taken_raw;
        out_illegal_d    = bus.res_valid & illegal_raw;
        out_mispredict_d = train_en & (taken_raw != bus.res_pred_taken);
        mp_count_d       = mp_count_q;
        if (out_mispredict_d && (mp_count_q != 32'hFFFF_FFFF)) begin
            mp_count_d = mp_count_q + 32'd1;
        end
    end

    // Result register; reset takes priority over a simultaneous resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            mp_count_q       <= 32'd0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_mispredict_q <= out_mispredict_d;
            out_illegal_q    <= out_illegal_d;
            mp_count_q       <= mp_count_d;
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.out_taken        = out_taken_q;
    assign bus.out_mispredict   = out_mispredict_q;
    assign bus.out_illegal      = out_illegal_q;
    assign bus.mispredict_count = mp_count_q;

endmodule
